// File: rtl/icb_regfile_slave_if.sv
// ---------------------------------------------------------------------------
// icb_regfile_slave_if
//
// ICB peripheral-port bundle between a bus master and the register-file
// slave. Command channel (valid/ready, address, read flag, write data and
// byte mask) and response channel (valid/ready, read data, error flag).
//
// Modports:
//   master - drives the command channel and rsp_ready
//   slave  - drives cmd_ready and the response channel
// ---------------------------------------------------------------------------
interface icb_regfile_slave_if;

    logic        i_icb_cmd_valid;
    logic        i_icb_cmd_ready;
    logic [31:0] i_icb_cmd_addr;
    logic        i_icb_cmd_read;
    logic [31:0] i_icb_cmd_wdata;
    logic [3:0]  i_icb_cmd_wmask;

    logic        i_icb_rsp_valid;
    logic        i_icb_rsp_ready;
    logic [31:0] i_icb_rsp_rdata;
    logic        i_icb_rsp_err;

    modport master (
        output i_icb_cmd_valid,
        output i_icb_cmd_addr,
        output i_icb_cmd_read,
        output i_icb_cmd_wdata,
        output i_icb_cmd_wmask,
        output i_icb_rsp_ready,
        input  i_icb_cmd_ready,
        input  i_icb_rsp_valid,
        input  i_icb_rsp_rdata,
        input  i_icb_rsp_err
    );

    modport slave (
        input  i_icb_cmd_valid,
        input  i_icb_cmd_addr,
        input  i_icb_cmd_read,
        input  i_icb_cmd_wdata,
        input  i_icb_cmd_wmask,
        input  i_icb_rsp_ready,
        output i_icb_cmd_ready,
        output i_icb_rsp_valid,
        output i_icb_rsp_rdata,
        output i_icb_rsp_err
    );

endinterface

// File: rtl/icb_regfile_slave.sv
// ---------------------------------------------------------------------------
// icb_regfile_slave
//
// Parametrised ICB register-file slave. Exposes NUM_RW software-writable
// control registers and NUM_RO hardware-driven status registers behind a
// single-slot registered response (one transaction per cycle when the
// master keeps rsp_ready high). Writes honour the byte mask; writes to the
// status window and any access outside the map return err = 1.
//
// Optional build macro: ICB_REGFILE_IRQ_EN
//   When defined, register NUM_RW-1 is a sticky IRQ status register
//   (set by irq_evt_i, write-1-to-clear, set beats clear) and register
//   NUM_RW-2 is its enable mask; irq_o is the registered OR of
//   status & enable. Needs NUM_RW >= 2. When undefined, every RW register
//   is plain, irq_evt_i is ignored and irq_o is tied low.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   bus         ICB slave modport (command + response channels)
//   rw_regs_o   flattened RW registers, reg k = [32k+31:32k]
//   wr_pulse_o  one-cycle strobe per RW register, high the cycle after write
//   ro_regs_i   flattened status inputs, sampled when a read is accepted
//   irq_evt_i   interrupt event pulses (IRQ build only)
//   irq_o       interrupt output (0 in the default build)
// ---------------------------------------------------------------------------
module icb_regfile_slave #(
    parameter int NUM_RW   = 32,
    parameter int NUM_RO   = 12,
    parameter int IDX_W    = 7,
    parameter int ADDR_LSB = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    icb_regfile_slave_if.slave                       bus,
    output logic [NUM_RW*32-1:0]                     rw_regs_o,
    output logic [NUM_RW-1:0]                        wr_pulse_o,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] ro_regs_i,
    input  logic [31:0]                              irq_evt_i,
    output logic                                     irq_o
);

    // Decode boundaries widened to 32 bits so comparisons stay width-clean.
    localparam logic [31:0] RW_END   = 32'(NUM_RW);
    localparam logic [31:0] RO_END   = 32'(NUM_RW + NUM_RO);
    localparam logic [31:0] IDX_MASK = ((32'd1 << IDX_W) - 32'd1) << ADDR_LSB;

    logic [NUM_RW-1:0][31:0] rw_q;
    logic [NUM_RW-1:0]       wr_hit;
    logic [NUM_RW-1:0]       wr_pulse_q;

    logic [IDX_W-1:0] cmd_idx;
    logic [31:0]      idx_ext;
    logic             cmd_accept;
    logic             is_rw;
    logic             is_ro;
    logic [31:0]      byte_mask;
    logic [31:0]      rw_rdata;
    logic [31:0]      ro_rdata;
    logic [31:0]      rsp_rdata_next;
    logic             rsp_err_next;

    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;

    // Address bits outside the index field carry no meaning for this block.
    logic unused_addr;
    assign unused_addr = ^(bus.i_icb_cmd_addr & ~IDX_MASK);

    assign cmd_idx = bus.i_icb_cmd_addr[ADDR_LSB +: IDX_W];
    assign idx_ext = 32'(cmd_idx);

    // The single response slot can take a new command whenever it is empty
    // or is being drained in this very cycle.
    assign bus.i_icb_cmd_ready = ~rsp_valid_q | bus.i_icb_rsp_ready;
    assign cmd_accept          = bus.i_icb_cmd_valid & bus.i_icb_cmd_ready;

    assign is_rw = (idx_ext < RW_END);
    assign is_ro = (idx_ext >= RW_END) && (idx_ext < RO_END);

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < 4; b++) begin
            byte_mask[8*b +: 8] = {8{bus.i_icb_cmd_wmask[b]}};
        end
    end

    // Read multiplexers written as compare loops so an index outside either
    // window simply yields zero instead of an out-of-range select.
    always_comb begin
        rw_rdata = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            if (idx_ext == 32'(k)) begin
                rw_rdata = rw_q[k];
            end
        end
    end

    always_comb begin
        ro_rdata = '0;
        for (int k = 0; k < NUM_RO; k++) begin
            if (idx_ext == RW_END + 32'(k)) begin
                ro_rdata = ro_regs_i[32*k +: 32];
            end
        end
    end

    // Writes always answer with zero data; only a write into the RW window
    // or a read of a mapped register is error-free.
    always_comb begin
        rsp_rdata_next = '0;
        if (bus.i_icb_cmd_read) begin
            if (is_rw) begin
                rsp_rdata_next = rw_rdata;
            end else if (is_ro) begin
                rsp_rdata_next = ro_rdata;
            end
        end
        rsp_err_next = ~is_rw & ~(is_ro & bus.i_icb_cmd_read);
    end

    // RW register bank. Each register owns its flop; the IRQ build turns
    // the top register into a sticky status register.
    for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
        logic [31:0] q;

        assign wr_hit[k] = cmd_accept & ~bus.i_icb_cmd_read & (idx_ext == 32'(k));
        assign rw_q[k]   = q;

`ifdef ICB_REGFILE_IRQ_EN
        if (k == NUM_RW - 1) begin : g_status
            // Clear first, then OR in new events so a same-cycle event wins.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else begin
                    q <= (q & ~(wr_hit[k] ? (bus.i_icb_cmd_wdata & byte_mask) : 32'd0))
                         | irq_evt_i;
                end
            end
        end else begin : g_plain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (wr_hit[k]) begin
                    q <= (q & ~byte_mask) | (bus.i_icb_cmd_wdata & byte_mask);
                end
            end
        end
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (wr_hit[k]) begin
                q <= (q & ~byte_mask) | (bus.i_icb_cmd_wdata & byte_mask);
            end
        end
`endif
    end

    assign rw_regs_o = rw_q;

    // Write strobes are delayed one cycle so they line up with the new
    // register value on rw_regs_o. An all-zero mask still strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_hit;
        end
    end

    assign wr_pulse_o = wr_pulse_q;

    // Response slot: loads on every accept (including one that coincides
    // with the drain of the previous response) and empties on a drain with
    // no replacement. Data and error hold while the master stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (cmd_accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_next;
            rsp_err_q   <= rsp_err_next;
        end else if (bus.i_icb_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.i_icb_rsp_valid = rsp_valid_q;
    assign bus.i_icb_rsp_rdata = rsp_rdata_q;
    assign bus.i_icb_rsp_err   = rsp_err_q;

`ifdef ICB_REGFILE_IRQ_EN
    // Interrupt follows status & enable one cycle later.
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(rw_q[NUM_RW-1] & rw_q[NUM_RW-2]);
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_evt;
    assign unused_evt = ^irq_evt_i;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_icb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_icb_regfile_slave
//
// Directed steps followed by a randomized phase, all checked every cycle
// against a transaction-level model: an array of register values, a queue
// of pending responses, and the write-strobe / interrupt expectations.
// ---------------------------------------------------------------------------
module tb_icb_regfile_slave;

    localparam int NUM_RW     = 32;
    localparam int NUM_RO     = 12;
    localparam int IDX_W      = 7;
    localparam int ADDR_LSB   = 2;
    localparam int STATUS_IDX = NUM_RW - 1;
    localparam int ENABLE_IDX = NUM_RW - 2;
    localparam logic [31:0] IDX_MASK = ((32'd1 << IDX_W) - 32'd1) << ADDR_LSB;
`ifdef ICB_REGFILE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_RW*32-1:0]   rw_regs_o;
    logic [NUM_RW-1:0]      wr_pulse_o;
    logic [NUM_RO*32-1:0]   ro_regs_i;
    logic [31:0]            irq_evt_i;
    logic                   irq_o;

    icb_regfile_slave_if bus ();

    icb_regfile_slave #(
        .NUM_RW   (NUM_RW),
        .NUM_RO   (NUM_RO),
        .IDX_W    (IDX_W),
        .ADDR_LSB (ADDR_LSB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rw_regs_o  (rw_regs_o),
        .wr_pulse_o (wr_pulse_o),
        .ro_regs_i  (ro_regs_i),
        .irq_evt_i  (irq_evt_i),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]       m_rw [NUM_RW];
    rsp_t              m_q[$];
    logic [NUM_RW-1:0] m_pulse;
    logic              m_irq;

    int          checks = 0;
    int          errors = 0;
    logic        obs_valid;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          pulse3_count;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < NUM_RW; k++) m_rw[k] = '0;
        m_q.delete();
        m_pulse = '0;
        m_irq   = 1'b0;
    endtask

    // Compare every DUT output against the model as it stands before the
    // coming clock edge.
    task automatic checkOutput();
        logic                 exp_valid;
        logic [NUM_RW*32-1:0] flat;
        int                   bad;
        exp_valid = (m_q.size() != 0);
        obs_valid = bus.i_icb_rsp_valid;
        obs_rdata = bus.i_icb_rsp_rdata;
        obs_err   = bus.i_icb_rsp_err;
        check32("rsp_valid", 32'(bus.i_icb_rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check32("rsp_rdata", bus.i_icb_rsp_rdata, m_q[0].rdata);
            check32("rsp_err", 32'(bus.i_icb_rsp_err), 32'(m_q[0].err));
        end
        check32("cmd_ready", 32'(bus.i_icb_cmd_ready), 32'(!exp_valid || bus.i_icb_rsp_ready));
        check32("wr_pulse", 32'(wr_pulse_o), 32'(m_pulse));
        check32("irq_o", 32'(irq_o), 32'(m_irq));
        for (int k = 0; k < NUM_RW; k++) flat[32*k +: 32] = m_rw[k];
        checks++;
        assert (rw_regs_o === flat) else begin
            errors++;
            bad = 0;
            for (int k = NUM_RW - 1; k >= 0; k--) begin
                if (rw_regs_o[32*k +: 32] !== flat[32*k +: 32]) bad = k;
            end
            $error("[TB] FAIL rw_regs_o[%0d] observed=%h expected=%h",
                   bad, rw_regs_o[32*bad +: 32], flat[32*bad +: 32]);
        end
        if (wr_pulse_o[3] === 1'b1) pulse3_count++;
    endtask

    // Advance the model across one clock edge using the inputs that the
    // DUT is about to sample.
    task automatic modelStep(input bit valid, input bit rd, input int idx,
                             input logic [31:0] wdata, input logic [3:0] wmask,
                             input bit rsp_ready, input logic [31:0] evt);
        bit          accept;
        bit          drain;
        logic [31:0] bm;
        logic [31:0] clear;
        logic        next_irq;
        rsp_t        r;
        drain    = (m_q.size() != 0) && rsp_ready;
        accept   = valid && ((m_q.size() == 0) || rsp_ready);
        next_irq = IRQ_EN ? |(m_rw[STATUS_IDX] & m_rw[ENABLE_IDX]) : 1'b0;
        m_pulse  = '0;
        clear    = '0;
        for (int b = 0; b < 4; b++) bm[8*b +: 8] = wmask[b] ? 8'hFF : 8'h00;
        if (drain) void'(m_q.pop_front());
        if (accept) begin
            r.rdata = '0;
            r.err   = 1'b0;
            if (idx < NUM_RW) begin
                if (rd) begin
                    r.rdata = m_rw[idx];
                end else begin
                    m_pulse[idx] = 1'b1;
                    if (IRQ_EN && idx == STATUS_IDX) clear = wdata & bm;
                    else m_rw[idx] = (m_rw[idx] & ~bm) | (wdata & bm);
                end
            end else if (idx < NUM_RW + NUM_RO) begin
                if (rd) r.rdata = ro_regs_i[32*(idx-NUM_RW) +: 32];
                else    r.err   = 1'b1;
            end else begin
                r.err = 1'b1;
            end
            m_q.push_back(r);
        end
        if (IRQ_EN) m_rw[STATUS_IDX] = (m_rw[STATUS_IDX] & ~clear) | evt;
        m_irq = next_irq;
    endtask

    // One bus cycle: drive at the falling edge, check, step the model.
    task automatic applyStimulus(input bit valid, input bit rd, input int idx,
                                 input logic [31:0] wdata, input logic [3:0] wmask,
                                 input bit rsp_ready, input logic [31:0] evt,
                                 input logic [31:0] junk);
        @(negedge clk);
        bus.i_icb_cmd_valid = valid;
        bus.i_icb_cmd_read  = rd;
        bus.i_icb_cmd_addr  = ((32'(idx) << ADDR_LSB) & IDX_MASK) | (junk & ~IDX_MASK);
        bus.i_icb_cmd_wdata = wdata;
        bus.i_icb_cmd_wmask = wmask;
        bus.i_icb_rsp_ready = rsp_ready;
        irq_evt_i           = evt;
        #1;
        checkOutput();
        modelStep(valid, rd, idx, wdata, wmask, rsp_ready, evt);
    endtask

    task automatic idle(input bit rsp_ready);
        applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0, rsp_ready, 32'h0, 32'h0);
    endtask

    task automatic rd(input int idx);
        applyStimulus(1'b1, 1'b1, idx, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
    endtask

    task automatic wr(input int idx, input logic [31:0] data, input logic [3:0] mask);
        applyStimulus(1'b1, 1'b0, idx, data, mask, 1'b1, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.i_icb_cmd_valid = 1'b0;
        bus.i_icb_cmd_read  = 1'b0;
        bus.i_icb_cmd_addr  = '0;
        bus.i_icb_cmd_wdata = '0;
        bus.i_icb_cmd_wmask = '0;
        bus.i_icb_rsp_ready = 1'b0;
        irq_evt_i           = '0;
        ro_regs_i           = '0;
        pulse3_count        = 0;
        modelReset();

        // Reset state
        idle(1'b0);
        idle(1'b1);
        check32("reset_rdata", bus.i_icb_rsp_rdata, 32'h0);
        check32("reset_err", 32'(bus.i_icb_rsp_err), 32'h0);
        rst_n = 1'b1;

        // All RW registers read zero, back to back
        for (int k = 0; k < NUM_RW; k++) rd(k);
        idle(1'b1);

        // Byte-masked writes to register 3
        pulse3_count = 0;
        wr(3, 32'hA5A5_5A5A, 4'hF);
        wr(3, 32'h1122_3344, 4'b0101);
        rd(3);
        idle(1'b1);
        check32("masked_write_rdata", obs_rdata, 32'hA522_5A44);
        check32("wr_pulse3_count", 32'(pulse3_count), 32'd2);

        // Backpressure then back-to-back reads
        wr(1, 32'h1111_1111, 4'hF);
        wr(2, 32'h2222_2222, 4'hF);
        rd(3);
        for (int c = 0; c < 5; c++)
            applyStimulus(1'b1, 1'b1, 1, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
        check32("stall_rdata", obs_rdata, 32'hA522_5A44);
        check32("stall_cmd_ready", 32'(bus.i_icb_cmd_ready), 32'h0);
        rd(1);
        rd(2);
        check32("b2b_first", obs_rdata, 32'h1111_1111);
        idle(1'b1);
        check32("b2b_second", obs_rdata, 32'h2222_2222);
        idle(1'b1);
        check32("b2b_drained", 32'(obs_valid), 32'h0);

        // Status window and unmapped accesses
        @(posedge clk);
        #1;
        ro_regs_i[31:0] = 32'hDEAD_BEEF;
        rd(NUM_RW);
        idle(1'b1);
        check32("ro_rdata", obs_rdata, 32'hDEAD_BEEF);
        check32("ro_err", 32'(obs_err), 32'h0);
        wr(NUM_RW, 32'hFFFF_FFFF, 4'hF);
        idle(1'b1);
        check32("ro_write_err", 32'(obs_err), 32'h1);
        check32("ro_write_rdata", obs_rdata, 32'h0);
        rd(127);
        idle(1'b1);
        check32("unmapped_err", 32'(obs_err), 32'h1);
        check32("unmapped_rdata", obs_rdata, 32'h0);

        // Asynchronous reset while a response is stalled
        applyStimulus(1'b1, 1'b1, 3, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
        idle(1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check32("async_rsp_valid", 32'(bus.i_icb_rsp_valid), 32'h0);
        check32("async_reg3", rw_regs_o[32*3 +: 32], 32'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NUM_RW; k++) rd(k);
        idle(1'b1);

`ifdef ICB_REGFILE_IRQ_EN
        // Interrupt set, clear, and set-beats-clear
        wr(ENABLE_IDX, 32'h1, 4'hF);
        applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1, 32'h1, 32'h0);
        idle(1'b1);
        idle(1'b1);
        check32("irq_set", 32'(irq_o), 32'h1);
        wr(STATUS_IDX, 32'h1, 4'hF);
        rd(STATUS_IDX);
        idle(1'b1);
        check32("irq_status_cleared", obs_rdata, 32'h0);
        check32("irq_cleared", 32'(irq_o), 32'h0);
        applyStimulus(1'b1, 1'b0, STATUS_IDX, 32'h1, 4'hF, 1'b1, 32'h1, 32'h0);
        rd(STATUS_IDX);
        idle(1'b1);
        check32("irq_set_wins", obs_rdata, 32'h1);
`endif

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            int          sel;
            int          idx;
            logic [31:0] evt;
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0)
                ro_regs_i[32*$urandom_range(0, NUM_RO-1) +: 32] = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 6)      idx = $urandom_range(0, NUM_RW-1);
            else if (sel < 8) idx = $urandom_range(NUM_RW, NUM_RW+NUM_RO-1);
            else              idx = $urandom_range(0, 127);
            evt = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'h0;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, idx,
                          $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3) != 0, evt, $urandom);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icb_regfile_slave.md
Name: icb_regfile_slave

Overview:
- Parametrised ICB register-file slave. Successor to the fixed 32-entry ICB register block.
- Provides NUM_RW software-writable control registers and NUM_RO hardware-driven status registers.
- Supports byte-masked writes, a registered response with backpressure for both reads and writes, and an error response.
- Sits on an ICB peripheral port. Drives control buses to accelerator or motor logic and samples status back.

Parameters:
- NUM_RW, 32, number of read/write registers (1..64).
- NUM_RO, 12, number of read-only status registers (0..64).
- IDX_W, 7, register index width; NUM_RW+NUM_RO <= 2**IDX_W.
- ADDR_LSB, 2, byte-to-word shift; index = i_icb_cmd_addr[ADDR_LSB+IDX_W-1:ADDR_LSB].

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_icb_cmd_valid  in  1  command valid.
- i_icb_cmd_ready  out  1  command accepted.
- i_icb_cmd_addr  in  32  byte address; bits outside the index field are ignored.
- i_icb_cmd_read  in  1  1 = read, 0 = write.
- i_icb_cmd_wdata  in  32  write data.
- i_icb_cmd_wmask  in  4  byte enables; bit n covers wdata[8n+7:8n].
- i_icb_rsp_valid  out  1  response valid.
- i_icb_rsp_ready  in  1  response accepted.
- i_icb_rsp_rdata  out  32  read data; 0 for writes and errors.
- i_icb_rsp_err  out  1  error response.
- rw_regs_o  out  NUM_RW*32  flattened RW registers; reg k = [32k+31:32k].
- wr_pulse_o  out  NUM_RW  one-cycle strobe, register k written this cycle.
- ro_regs_i  in  NUM_RO*32  flattened status inputs, sampled at command accept.
- irq_evt_i  in  32  event pulses (used only with the optional feature).
- irq_o  out  1  interrupt (0 without the optional feature).

Behaviour:
- Reset (rst_n low, asynchronous): all RW registers 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, wr_pulse_o 0, irq_o 0.
- Accept: the command is accepted when i_icb_cmd_valid & i_icb_cmd_ready.
- cmd_ready = ~rsp_valid | i_icb_rsp_ready. One response slot, throughput of one transaction per cycle when rsp_ready is held high.
- Latency: rsp_valid rises on the cycle after accept, for both reads and writes.
- rsp_valid, rdata and err hold stable until rsp_valid & rsp_ready. If no new accept occurs in that handshake cycle, rsp_valid returns to 0 on the next cycle.
- Handshake and new accept in the same cycle: rsp_valid stays 1 and rdata/err load the new response.
- Decode by idx:
  - idx < NUM_RW: RW register.
  - NUM_RW <= idx < NUM_RW+NUM_RO: RO register.
  - Otherwise: unmapped.
- RW write: register updates at the accept edge, per byte under wmask. wmask = 0 leaves the register unchanged, but wr_pulse_o[idx] still asserts and err = 0. wr_pulse_o[idx] is high for exactly the cycle after the accept edge.
- RW read: rdata = register value at accept. A read from the same register in the cycle after a write returns the new value.
- RO read: rdata = ro_regs_i slice sampled at the accept edge.
- RO write: no state change, err = 1.
- Unmapped read or write: no state change, rdata = 0, err = 1.
- Commands are never dropped: every accepted command produces exactly one response, in order.
- rw_regs_o is driven directly from the register flops with no extra latency.

Optional Feature:
- Macro: ICB_REGFILE_IRQ_EN.
- Defined:
  - Register NUM_RW-1 becomes an IRQ status register.
    - Each cycle, bits set where irq_evt_i = 1.
    - A software write clears the bits written 1 under wmask (write-1-to-clear).
    - Set wins over clear on the same bit in the same cycle.
  - Register NUM_RW-2 is the IRQ enable register (normal RW).
  - irq_o is registered: irq_o = |(status & enable), one cycle after status/enable change.
  - Requires NUM_RW >= 2.
- Undefined: register NUM_RW-1 is a plain RW register, irq_evt_i is ignored, irq_o is tied 0.

Test Plan:
- Reset, then read idx 0..NUM_RW-1: all rdata 0x00000000, err 0, each rsp_valid one cycle after accept.
- Write idx 3 = 0xA5A5_5A5A with wmask 0xF, then write idx 3 = 0x1122_3344 with wmask 0b0101, then read idx 3: rdata 0xA522_5A44. wr_pulse_o[3] pulses once per write.
- rsp_ready held 0 for 5 cycles after a read: rsp_valid and rdata stable and cmd_ready 0 throughout. Then back-to-back reads of idx 1 and 2 with rsp_ready = 1: one response per cycle, in order.
- ro_regs_i slot 0 = 0xDEAD_BEEF, read idx NUM_RW (addr 0x80 with defaults): rdata 0xDEADBEEF, err 0. Write to the same address: err 1, rdata 0. Read idx 127: err 1, rdata 0.
- Assert rst_n low while rsp_valid = 1 with rsp_ready = 0: rsp_valid drops immediately (asynchronous), all RW registers read back 0 after release.
- ICB_REGFILE_IRQ_EN: enable = 0x1, pulse irq_evt_i = 0x1, irq_o = 1 on the following cycle. Write 0x1 to the status register: status reads 0 and irq_o = 0. Pulse the event in the same cycle as the clear write: status bit remains 1.
